// File: rtl/ls374_bus_arbiter.sv
//------------------------------------------------------------------------------
// ls374_bus_arbiter: round-robin owner of a shared LS374 latch bus, with a
// turnaround cycle between owners. Define LS374_ARB_FIXED_PRIO_EN for fixed
// priority (lowest index wins). Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ls374_bus_arbiter #(
   parameter int N_REQ       = 4,
   parameter int DW          = 8,
   parameter int HOLD_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [N_REQ-1:0]      req,
   input  logic [N_REQ*DW-1:0]   req_data,
   output logic [N_REQ-1:0]      ack,
   output logic [N_REQ-1:0]      le,
   output logic [N_REQ-1:0]      oe_n,
   output logic [DW-1:0]         bus_q,
   output logic                  bus_valid,
   output logic                  busy
);

   localparam int GW = $clog2(N_REQ);
   localparam int CW = $clog2(HOLD_CYCLES + 1);
   localparam logic [GW-1:0] LAST_INIT = GW'(N_REQ - 1);
   localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LATCH = 2'd1,
      S_DRIVE = 2'd2,
      S_TURN  = 2'd3
   } state_t;

   state_t              state_q;
   logic [GW-1:0]       grant_q;
   logic [GW-1:0]       last_q;
   logic [CW-1:0]       cnt_q;
   logic [DW-1:0]       hold_q;
   logic [N_REQ-1:0]    ack_q;
   logic [N_REQ-1:0]    oe_n_q;
   logic [DW-1:0]       bus_q_q;
   logic                valid_q;
   logic                busy_q;

   logic [GW-1:0]       grant_d;
   logic [N_REQ-1:0]    grant_oh;

   assign grant_oh = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;

`ifdef LS374_ARB_FIXED_PRIO_EN
   always_comb begin
      grant_d = last_q;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i]) grant_d = GW'(i);
      end
   end
`else
   // Scan from last_grant+1 upward with wrap; the final iteration revisits last_grant.
   always_comb begin
      logic found;
      int   idx;
      grant_d = last_q;
      found   = 1'b0;
      idx     = 0;
      for (int off = 1; off <= N_REQ; off++) begin
         idx = (int'(last_q) + off) % N_REQ;
         if (!found && req[idx]) begin
            grant_d = GW'(idx);
            found   = 1'b1;
         end
      end
   end
`endif

   // Outputs are registered, so each state's bus effect appears one edge after entry.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         last_q  <= LAST_INIT;
         cnt_q   <= '0;
         hold_q  <= '0;
         ack_q   <= '0;
         oe_n_q  <= '1;
         bus_q_q <= '1;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               ack_q   <= '0;
               oe_n_q  <= '1;
               bus_q_q <= '1;
               valid_q <= 1'b0;
               if (|req) begin
                  grant_q <= grant_d;
                  state_q <= S_LATCH;
                  busy_q  <= 1'b1;
               end else begin
                  busy_q  <= 1'b0;
               end
            end
            S_LATCH: begin
               hold_q  <= req_data[grant_q*DW +: DW];
               ack_q   <= grant_oh;
               last_q  <= grant_q;
               cnt_q   <= HOLD_INIT;
               state_q <= S_DRIVE;
               busy_q  <= 1'b1;
            end
            S_DRIVE: begin
               ack_q   <= '0;
               oe_n_q  <= ~grant_oh;
               bus_q_q <= hold_q;
               valid_q <= 1'b1;
               if (cnt_q == '0) begin
                  state_q <= S_TURN;
               end else begin
                  cnt_q   <= cnt_q - 1'b1;
               end
               busy_q  <= 1'b1;
            end
            default: begin
               ack_q   <= '0;
               oe_n_q  <= '1;
               bus_q_q <= '1;
               valid_q <= 1'b0;
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ack       = ack_q;
   assign le        = ack_q;
   assign oe_n      = oe_n_q;
   assign bus_q     = bus_q_q;
   assign bus_valid = valid_q;
   assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_ls374_bus_arbiter.sv
// Directed-vector bench for ls374_bus_arbiter (N_REQ=4, DW=8, HOLD_CYCLES=2).
`default_nettype none

module tb_ls374_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  ack, le, oe_n;
   logic [7:0]  bus_q;
   logic        bus_valid, busy;

   int n_vec  = 0;
   int n_fail = 0;

   localparam logic [31:0] D = 32'h44A5_5A11;

   ls374_bus_arbiter #(.N_REQ(4), .DW(8), .HOLD_CYCLES(2)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
      .ack(ack), .le(le), .oe_n(oe_n), .bus_q(bus_q),
      .bus_valid(bus_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req;
      logic [3:0] ack;
      logic [3:0] oe_n;
      logic [7:0] bus;
      logic       valid;
      logic       busy;
   } vec_t;

   vec_t tbl[13];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_ack(output logic [3:0] a, output int cyc);
      a   = '0;
      cyc = 0;
      while (a == 4'b0 && cyc < 20) begin
         tick();
         cyc++;
         a = ack;
      end
      if (a == 4'b0) begin
         n_vec++;
         n_fail++;
         $display("FAIL ack_timeout: got no ack within %0d cycles", cyc);
      end
   endtask

   function automatic logic [3:0] oh(input int g);
      logic [3:0] one;
      one = 4'b0001;
      return one << g;
   endfunction

   function automatic logic [7:0] byte_of(input int g);
      logic [31:0] d;
      d = D >> (8 * g);
      return d[7:0];
   endfunction

   initial begin
      logic [3:0] a;
      int         c;
      int         rr[5];
      int         alt[3];

      // req / ack / oe_n / bus / valid / busy after each edge
      tbl[0]  = '{4'b0100, 4'b0000, 4'b1111, 8'hFF, 1'b0, 1'b1};
      tbl[1]  = '{4'b0100, 4'b0100, 4'b1111, 8'hFF, 1'b0, 1'b1};
      tbl[2]  = '{4'b0000, 4'b0000, 4'b1011, 8'hA5, 1'b1, 1'b1};
      tbl[3]  = '{4'b0000, 4'b0000, 4'b1011, 8'hA5, 1'b1, 1'b1};
      tbl[4]  = '{4'b0000, 4'b0000, 4'b1111, 8'hFF, 1'b0, 1'b0};
      tbl[5]  = '{4'b0000, 4'b0000, 4'b1111, 8'hFF, 1'b0, 1'b0};
      tbl[6]  = '{4'b0010, 4'b0000, 4'b1111, 8'hFF, 1'b0, 1'b1};
      tbl[7]  = '{4'b0010, 4'b0010, 4'b1111, 8'hFF, 1'b0, 1'b1};
      tbl[8]  = '{4'b0000, 4'b0000, 4'b1101, 8'h5A, 1'b1, 1'b1};
      tbl[9]  = '{4'b1000, 4'b0000, 4'b1101, 8'h5A, 1'b1, 1'b1};
      tbl[10] = '{4'b1000, 4'b0000, 4'b1111, 8'hFF, 1'b0, 1'b0};
      tbl[11] = '{4'b0000, 4'b0000, 4'b1111, 8'hFF, 1'b0, 1'b0};
      tbl[12] = '{4'b0000, 4'b0000, 4'b1111, 8'hFF, 1'b0, 1'b0};

`ifdef LS374_ARB_FIXED_PRIO_EN
      rr  = '{0, 0, 0, 0, 0};
      alt = '{1, 1, 1};
`else
      rr  = '{0, 1, 2, 3, 0};
      alt = '{1, 3, 1};
`endif

      reset_n  = 1'b0;
      req      = 4'b0;
      req_data = D;
      tick();
      tick();
      chk("reset_state", {ack, le, oe_n, bus_q, bus_valid, busy},
          {4'b0, 4'b0, 4'b1111, 8'hFF, 1'b0, 1'b0});
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < 13; i++) begin
         req = tbl[i].req;
         tick();
         chk($sformatf("vec%0d", i), {ack, le, oe_n, bus_q, bus_valid, busy},
             {tbl[i].ack, tbl[i].ack, tbl[i].oe_n, tbl[i].bus, tbl[i].valid, tbl[i].busy});
      end

      // Reset while driving: last grant was 1, so round-robin picks 2 next.
      req = 4'b1111;
      wait_ack(a, c);
`ifdef LS374_ARB_FIXED_PRIO_EN
      chk("pre_reset_grant", a, 4'b0001);
`else
      chk("pre_reset_grant", a, 4'b0100);
`endif
      tick();
      chk("pre_reset_drive", bus_valid, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_reset", {ack, oe_n, bus_q, bus_valid, busy},
          {4'b0, 4'b1111, 8'hFF, 1'b0, 1'b0});
      tick();
      reset_n = 1'b1;

      for (int k = 0; k < 5; k++) begin
         wait_ack(a, c);
         chk($sformatf("rr_grant%0d", k), a, oh(rr[k]));
         if (k > 0) chk($sformatf("rr_spacing%0d", k), c, 4);
         tick();
         chk($sformatf("rr_drive%0d", k), {oe_n, bus_q, bus_valid},
             {~oh(rr[k]), byte_of(rr[k]), 1'b1});
      end

      req = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         wait_ack(a, c);
         chk($sformatf("alt_grant%0d", k), a, oh(alt[k]));
         tick();
      end

      for (int i = 0; i < 2000; i++) begin
         req      = 4'($urandom);
         req_data = $urandom;
         tick();
         chk("exclusive", {($countones(~oe_n) <= 1), (bus_valid || bus_q == 8'hFF),
                           (bus_valid == (oe_n != 4'hF))}, 3'b111);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
